// File: rtl/enc_pkg.sv
// Shared definitions for the function-4 encrypt scheduler: widths, FSM state codes, default seed.
package enc_pkg;

   localparam int unsigned DATA_W  = 60;
   localparam int unsigned R11_W   = 11;
   localparam int unsigned R6_W    = 6;
   localparam int unsigned FRAME_W = 78;
   localparam int unsigned SUM_W   = DATA_W + 1;
   localparam int unsigned LFSR_W  = 16;

   localparam logic [LFSR_W-1:0] LFSR_SEED_DEFAULT = 16'hACE1;

   typedef logic [1:0] state_t;

   localparam state_t ST_IDLE = 2'd0;
   localparam state_t ST_CALC = 2'd1;
   localparam state_t ST_HOLD = 2'd2;

endpackage

// File: rtl/enc4_scheduler_if.sv
// Requester and frame-sink signals of enc4_scheduler grouped as one bundle.
// slave: the scheduler side; master: the sources/sink side.
interface enc4_scheduler_if;
   import enc_pkg::*;

   logic                req0_valid;
   logic [DATA_W-1:0]   req0_data;
   logic                req0_ready;
   logic                req1_valid;
   logic [DATA_W-1:0]   req1_data;
   logic                req1_ready;
   logic                out_valid;
   logic [FRAME_W-1:0]  out_enc;
   logic                out_src;
   logic                out_ready;

   modport slave (
      input  req0_valid, req0_data, req1_valid, req1_data, out_ready,
      output req0_ready, req1_ready, out_valid, out_enc, out_src
   );

   modport master (
      output req0_valid, req0_data, req1_valid, req1_data, out_ready,
      input  req0_ready, req1_ready, out_valid, out_enc, out_src
   );

endinterface

// File: rtl/enc4_datapath.sv
// Function-4 encrypt datapath: builds the 60-bit mask from rand_11 and adds it to the
// plaintext at 61 bits so the carry is kept.
module enc4_datapath
   import enc_pkg::*;
(
   input  logic [DATA_W-1:0] data_i,
   input  logic [R11_W-1:0]  r_i,
   output logic [SUM_W-1:0]  sum_o
);

   logic [DATA_W-1:0] mask;

   // Mask fields from MSB down: r[4:0], ~r, r, ~r, ~r, r.
   always_comb begin
      mask  = {r_i[4:0], ~r_i, r_i, ~r_i, ~r_i, r_i};
      sum_o = {1'b0, data_i} + {1'b0, mask};
   end

endmodule

// File: rtl/enc4_lfsr.sv
// 16-bit Fibonacci LFSR, x^16+x^14+x^13+x^11+1, stepping only when advance_i is high.
module enc4_lfsr
   import enc_pkg::*;
#(
   parameter logic [LFSR_W-1:0] SEED = LFSR_SEED_DEFAULT
) (
   input  logic              clk_i,
   input  logic              rst_i,
   input  logic              advance_i,
   output logic [LFSR_W-1:0] state_o
);

   logic [LFSR_W-1:0] lfsr_q, lfsr_d;

   // One shift per advance; feedback taps at bits 15, 13, 12, 10.
   always_comb begin
      lfsr_d = lfsr_q;
      if (advance_i) begin
         lfsr_d = {lfsr_q[14:0], lfsr_q[15] ^ lfsr_q[13] ^ lfsr_q[12] ^ lfsr_q[10]};
      end
   end

   // State register with synchronous reset to the seed.
   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         lfsr_q <= SEED;
      end else begin
         lfsr_q <= lfsr_d;
      end
   end

   assign state_o = lfsr_q;

endmodule

// File: rtl/enc4_scheduler.sv
// Round-robin scheduler for two plaintext requesters feeding the function-4 encrypt datapath.
// Config macro ENC4_LFSR_EN: when defined the random pair comes from an internal LFSR,
// otherwise from the key_11/key_6 ports sampled at grant.
module enc4_scheduler
   import enc_pkg::*;
#(
   parameter logic [LFSR_W-1:0] LFSR_SEED = LFSR_SEED_DEFAULT
) (
   input  logic               Clk,
   input  logic               Rst,
   enc4_scheduler_if.slave    bus
`ifndef ENC4_LFSR_EN
   ,
   input  logic [R11_W-1:0]   key_11,
   input  logic [R6_W-1:0]    key_6
`endif
);

   // An all-zero seed would lock the LFSR.
   if (LFSR_SEED == '0) begin : g_seed_zero
      $error("enc4_scheduler: LFSR_SEED must be nonzero");
   end

   state_t             state_q, state_d;
   logic               last_grant_q, last_grant_d;
   logic [DATA_W-1:0]  data_q, data_d;
   logic               src_q, src_d;
   logic [R11_W-1:0]   r11_q, r11_d;
   logic [R6_W-1:0]    r6_q, r6_d;
   logic [FRAME_W-1:0] out_enc_q, out_enc_d;
   logic               out_src_q, out_src_d;
   logic               out_valid_q, out_valid_d;

   logic               grant;
   logic               gnt_src;
   logic [R11_W-1:0]   rand_11;
   logic [R6_W-1:0]    rand_6;
   logic [SUM_W-1:0]   sum;

`ifdef ENC4_LFSR_EN
   logic [LFSR_W-1:0]  lfsr_state;

   enc4_lfsr #(
      .SEED (LFSR_SEED)
   ) u_lfsr (
      .clk_i     (Clk),
      .rst_i     (Rst),
      .advance_i (grant),
      .state_o   (lfsr_state)
   );

   // rand_11 and rand_6 overlap on bit 10 by design.
   assign rand_11 = lfsr_state[10:0];
   assign rand_6  = lfsr_state[15:10];
`else
   assign rand_11 = key_11;
   assign rand_6  = key_6;
`endif

   enc4_datapath u_datapath (
      .data_i (data_q),
      .r_i    (r11_q),
      .sum_o  (sum)
   );

   // Arbitration: on a tie the requester that did not win last time gets the grant.
   always_comb begin
      grant          = (state_q == ST_IDLE) && (bus.req0_valid || bus.req1_valid);
      gnt_src        = (bus.req0_valid && bus.req1_valid) ? ~last_grant_q : bus.req1_valid;
      bus.req0_ready = grant && !gnt_src;
      bus.req1_ready = grant && gnt_src;
   end

   // FSM next state, capture at grant, frame registration in CALC.
   always_comb begin
      state_d      = state_q;
      last_grant_d = last_grant_q;
      data_d       = data_q;
      src_d        = src_q;
      r11_d        = r11_q;
      r6_d         = r6_q;
      out_enc_d    = out_enc_q;
      out_src_d    = out_src_q;
      out_valid_d  = out_valid_q;
      case (state_q)
         ST_IDLE: begin
            if (grant) begin
               state_d      = ST_CALC;
               data_d       = gnt_src ? bus.req1_data : bus.req0_data;
               src_d        = gnt_src;
               r11_d        = rand_11;
               r6_d         = rand_6;
               last_grant_d = gnt_src;
            end
         end
         ST_CALC: begin
            state_d     = ST_HOLD;
            out_enc_d   = {r11_q, sum, r6_q};
            out_src_d   = src_q;
            out_valid_d = 1'b1;
         end
         ST_HOLD: begin
            if (bus.out_ready) begin
               state_d     = ST_IDLE;
               out_valid_d = 1'b0;
            end
         end
         default: begin
            state_d     = ST_IDLE;
            out_valid_d = 1'b0;
         end
      endcase
   end

   // State registers; reset discards any in-flight frame.
   always_ff @(posedge Clk) begin
      if (Rst) begin
         state_q      <= ST_IDLE;
         last_grant_q <= 1'b1;
         data_q       <= '0;
         src_q        <= 1'b0;
         r11_q        <= '0;
         r6_q         <= '0;
         out_enc_q    <= '0;
         out_src_q    <= 1'b0;
         out_valid_q  <= 1'b0;
      end else begin
         state_q      <= state_d;
         last_grant_q <= last_grant_d;
         data_q       <= data_d;
         src_q        <= src_d;
         r11_q        <= r11_d;
         r6_q         <= r6_d;
         out_enc_q    <= out_enc_d;
         out_src_q    <= out_src_d;
         out_valid_q  <= out_valid_d;
      end
   end

   assign bus.out_valid = out_valid_q;
   assign bus.out_enc   = out_enc_q;
   assign bus.out_src   = out_src_q;

endmodule

// File: tb/tb_enc4_scheduler.sv
// Self-checking bench for enc4_scheduler: transaction-level model plus directed literal checks.
// Works in both the default (external key) build and the ENC4_LFSR_EN build.
module tb_enc4_scheduler;
   import enc_pkg::*;

   logic Clk = 1'b0;
   logic Rst;
   always #5 Clk = ~Clk;

   enc4_scheduler_if bus();

`ifndef ENC4_LFSR_EN
   logic [10:0] key_11;
   logic [5:0]  key_6;
`endif

   enc4_scheduler #(
      .LFSR_SEED (16'hACE1)
   ) dut (
      .Clk    (Clk),
      .Rst    (Rst),
      .bus    (bus)
`ifndef ENC4_LFSR_EN
      ,
      .key_11 (key_11),
      .key_6  (key_6)
`endif
   );

   int total = 0;
   int bad   = 0;
   int cyc   = 0;
   bit chk_en = 1'b0;

   task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
      end
   endtask

   // ---------------- model ----------------
   // Mask built bit by bit: 11-bit groups 1, 2 and 4 are inverted, top group reuses r[4:0].
   function automatic logic [59:0] mask_of(input logic [10:0] r);
      logic [59:0] m;
      for (int i = 0; i < 60; i++) begin
         int g;
         g = i / 11;
         m[i] = r[i % 11] ^ ((g == 1) || (g == 2) || (g == 4));
      end
      return m;
   endfunction

   function automatic logic [15:0] lfsr_next(input logic [15:0] s);
      return {s[14:0], s[15] ^ s[13] ^ s[12] ^ s[10]};
   endfunction

   logic        m_pending;
   int          m_age;
   logic        m_last;
   logic [77:0] m_frame;
   logic        m_src;
   logic [15:0] m_lfsr;

   function automatic logic pick(input logic v0, input logic v1, input logic last);
      if (v0 && v1) return ~last;
      return v1;
   endfunction

   always @(posedge Clk) begin : model
      logic        g;
      logic [10:0] r;
      logic [5:0]  r6;
      logic [59:0] d;
      logic [60:0] s;
      if (Rst) begin
         m_pending <= 1'b0;
         m_age     <= 0;
         m_last    <= 1'b1;
         m_lfsr    <= 16'hACE1;
      end else if (m_pending) begin
         if (m_age >= 1 && bus.out_ready) m_pending <= 1'b0;
         m_age <= m_age + 1;
      end else if (bus.req0_valid || bus.req1_valid) begin
         g = pick(bus.req0_valid, bus.req1_valid, m_last);
         d = g ? bus.req1_data : bus.req0_data;
`ifdef ENC4_LFSR_EN
         r  = m_lfsr[10:0];
         r6 = m_lfsr[15:10];
`else
         r  = key_11;
         r6 = key_6;
`endif
         s = 61'(d) + 61'(mask_of(r));
         m_frame   <= {r, s, r6};
         m_src     <= g;
         m_last    <= g;
         m_pending <= 1'b1;
         m_age     <= 0;
         m_lfsr    <= lfsr_next(m_lfsr);
      end
   end

   always @(posedge Clk) cyc <= cyc + 1;

   // ---------------- per-cycle compare ----------------
   always @(negedge Clk) begin
      logic g;
      if (chk_en) begin
         g = pick(bus.req0_valid, bus.req1_valid, m_last);
         check("req0_ready", 128'(bus.req0_ready),
               128'(!m_pending && bus.req0_valid && !g));
         check("req1_ready", 128'(bus.req1_ready),
               128'(!m_pending && bus.req1_valid && g));
         check("out_valid", 128'(bus.out_valid), 128'(m_pending && m_age >= 1));
         if (m_pending && m_age >= 1) begin
            check("out_enc", 128'(bus.out_enc), 128'(m_frame));
            check("out_src", 128'(bus.out_src), 128'(m_src));
         end
      end
   end

   // Record delivered frames during the streaming test.
   bit in_stream = 1'b0;
   int hs_src[$];
   int hs_cyc[$];
   always @(negedge Clk) begin
      if (in_stream && bus.out_valid && bus.out_ready) begin
         hs_src.push_back(int'(bus.out_src));
         hs_cyc.push_back(cyc);
      end
   end

   task automatic step(input int n);
      repeat (n) @(posedge Clk);
      #1;
   endtask

   task automatic set_keys(input logic [10:0] k11, input logic [5:0] k6);
`ifndef ENC4_LFSR_EN
      key_11 = k11;
      key_6  = k6;
`else
      if (k11 == k11 && k6 == k6) begin end
`endif
   endtask

   // ---------------- stimulus ----------------
   initial begin
      int src_exp [4];
      src_exp = '{1, 0, 1, 0};

      Rst            = 1'b1;
      bus.req0_valid = 1'b0;
      bus.req1_valid = 1'b0;
      bus.req0_data  = '0;
      bus.req1_data  = '0;
      bus.out_ready  = 1'b0;
      set_keys(11'h4E1, 6'h2B);
      step(1);
      chk_en = 1'b1;
      step(1);

      // Reset values, then a lone request with zero data.
      Rst            = 1'b0;
      bus.req0_valid = 1'b1;
      bus.out_ready  = 1'b1;
      @(negedge Clk);
      check("rst_out_valid", 128'(bus.out_valid), 128'(0));
      check("rst_out_enc", 128'(bus.out_enc), 128'(0));
      check("rst_out_src", 128'(bus.out_src), 128'(0));
      check("first_grant_req0", 128'(bus.req0_ready), 128'(1));
      step(1);
      bus.req0_valid = 1'b0;
      step(1);
      @(negedge Clk);
      check("t1_valid", 128'(bus.out_valid), 128'(1));
      check("t1_r11", 128'(bus.out_enc[77:67]), 128'(11'h4E1));
      check("t1_r6", 128'(bus.out_enc[5:0]), 128'(6'h2B));
      check("t1_mask_lo", 128'(bus.out_enc[16:6]), 128'(11'h4E1));
      check("t1_mask_inv", 128'(bus.out_enc[27:17]), 128'(11'h31E));
      check("t1_carry0", 128'(bus.out_enc[66]), 128'(0));
      check("t1_src", 128'(bus.out_src), 128'(0));

      // Both requesters streaming with the sink always ready.
      step(1);
      bus.req0_valid = 1'b1;
      bus.req1_valid = 1'b1;
      bus.req0_data  = 60'h123_4567_89AB_CDEF;
      bus.req1_data  = 60'hFED_CBA9_8765_4321;
      in_stream = 1'b1;
      for (int k = 0; k < 14; k++) begin
         set_keys(11'(k * 37 + 5), 6'(k * 11 + 3));
         step(1);
      end
      in_stream = 1'b0;
      total++;
      if (hs_src.size() < 4) begin
         bad++;
         $display("FAIL stream_count: got %0d frames expected at least 4", hs_src.size());
      end else begin
         for (int i = 0; i < 4; i++) check("stream_src", 128'(hs_src[i]), 128'(src_exp[i]));
         for (int i = 1; i < 4; i++)
            check("stream_gap", 128'(hs_cyc[i] - hs_cyc[i-1]), 128'(3));
      end
      bus.req0_valid = 1'b0;
      bus.req1_valid = 1'b0;
      step(4);

`ifndef ENC4_LFSR_EN
      // Carry out of the 60-bit add lands in out_enc[66].
      set_keys(11'h7FF, 6'h15);
      bus.req0_data  = 60'hFFF_FFFF_FFFF_FFFF;
      bus.req0_valid = 1'b1;
      step(1);
      bus.req0_valid = 1'b0;
      step(1);
      @(negedge Clk);
      check("carry_bit", 128'(bus.out_enc[66]), 128'(1));
      check("carry_top5", 128'(bus.out_enc[65:61]), 128'(5'h1F));
      check("carry_mid", 128'(bus.out_enc[49:39]), 128'(11'h7FF));
      check("carry_low", 128'(bus.out_enc[16:6]), 128'(11'h7FE));
      step(3);
`endif

      // Backpressure: sink stalls for 10 cycles while both requesters wait.
      bus.out_ready  = 1'b0;
      bus.req1_data  = 60'h0AA_5555_AAAA_0F0F;
      bus.req0_valid = 1'b1;
      bus.req1_valid = 1'b1;
      set_keys(11'h2C3, 6'h11);
      step(2);
      set_keys(11'h0F0, 6'h3C);
      step(10);
      @(negedge Clk);
      check("bp_valid", 128'(bus.out_valid), 128'(1));
      check("bp_ready0", 128'(bus.req0_ready), 128'(0));
      check("bp_ready1", 128'(bus.req1_ready), 128'(0));
      step(1);
      bus.out_ready = 1'b1;
      step(3);
      bus.req0_valid = 1'b0;
      bus.req1_valid = 1'b0;
      step(4);

      // Reset during CALC discards the frame and restores the tie-break.
      bus.req0_valid = 1'b1;
      bus.req1_valid = 1'b1;
      set_keys(11'h4E1, 6'h2B);
      step(1);
      Rst = 1'b1;
      step(1);
      Rst = 1'b0;
      @(negedge Clk);
      check("rst_calc_valid", 128'(bus.out_valid), 128'(0));
      check("rst_calc_gnt0", 128'(bus.req0_ready), 128'(1));
      check("rst_calc_gnt1", 128'(bus.req1_ready), 128'(0));
      step(1);
      bus.req0_valid = 1'b0;
      bus.req1_valid = 1'b0;
      step(1);
      @(negedge Clk);
      check("rst_calc_src", 128'(bus.out_src), 128'(0));
      check("rst_calc_r11", 128'(bus.out_enc[77:67]), 128'(11'h4E1));
      step(3);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

   // Hard time limit so the run always ends.
   initial begin
      #200000;
      $display("FAIL timeout: got no finish expected finish");
      $fatal(1, "timeout");
   end

endmodule
